// File: rtl/writeback_commit.sv
// ---------------------------------------------------------------------------
// writeback_commit
//
// Registered commit stage: the last pipeline stage before the register file
// and CSR file. It accepts one instruction per cycle from the memory stage
// with a valid/ready handshake. Every output is a flop, so an accepted
// instruction shows its effects exactly one cycle after the transfer.
//
// Each accepted instruction is resolved by priority:
//   1. An enabled pending interrupt traps (interupt=1, ecp = pc_in).
//   2. Otherwise a synchronous exception traps (interupt=0, ecp = pc_in).
//   3. Otherwise the instruction retires. It writes rd (never x0), may write
//      a CSR and may signal mret. A WFI parks the stage in SLEEP.
// Every trap is followed by one FLUSH cycle. In that cycle the instruction
// already in flight is consumed and dropped.
//
// Interrupt priority and cause codes (highest first):
//   eip (11) > sip (3) > tip (7) > local[N-1] (16+N-1) > ... > local[0] (16)
//
// Parameters
//   XLEN           datapath width (pc, data, ecp)
//   NUM_LOCAL_IRQ  local interrupt lines, 0..16 (cause 16+i)
//   CNT_W          perf counter width
//
// Ports
//   clk, rst_n                 clock; asynchronous active-low reset
//   valid_in / ready_out       handshake; transfer = valid_in && ready_out
//   pc_in, next_pc_in          pc and fall-through pc of the instruction
//   alu/csr/load_data_in       rd data sources
//   write_select_in            00 alu, 01 csr, 10 load, 11 next_pc
//   rd_address_in              destination register
//   csr_address_in, csr_write_in, mret_in, wfi_in, exception_in, ecause_in
//   eip, sip, tip, local_ip    pending interrupt lines (level)
//   irq_mask                   {local[N-1:0], eip, sip, tip} enables
//   global_ie                  global interrupt enable
//   rd_we/rd_address/rd_data   register file write
//   csr_write/csr_address/csr_data  CSR write (data comes from the ALU)
//   traped, mret, interupt, retired  one-cycle pulses
//   ecause, ecp                trap cause and trap pc (both hold)
//   sleeping                   stage is waiting in WFI
//   instret_count, trap_count  perf counters
//
// Configuration macro
//   WB_PERF_COUNTERS_EN  when defined, instret_count counts retired pulses and
//                        trap_count counts traped pulses. Both wrap modulo
//                        2^CNT_W. When undefined, no counter flops are built
//                        and both outputs are tied to zero.
// ---------------------------------------------------------------------------
module writeback_commit #(
  parameter int XLEN          = 32,
  parameter int NUM_LOCAL_IRQ = 4,
  parameter int CNT_W         = 64,
  // A zero-line configuration still needs a legal vector width.
  localparam int LIRQ_W       = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   next_pc_in,
  input  logic [XLEN-1:0]   alu_data_in,
  input  logic [XLEN-1:0]   csr_data_in,
  input  logic [XLEN-1:0]   load_data_in,
  input  logic [1:0]        write_select_in,
  input  logic [4:0]        rd_address_in,
  input  logic [11:0]       csr_address_in,
  input  logic              csr_write_in,
  input  logic              mret_in,
  input  logic              wfi_in,
  input  logic              exception_in,
  input  logic [3:0]        ecause_in,
  input  logic              eip,
  input  logic              sip,
  input  logic              tip,
  input  logic [LIRQ_W-1:0] local_ip,
  input  logic [LIRQ_W+2:0] irq_mask,
  input  logic              global_ie,
  output logic              rd_we,
  output logic [4:0]        rd_address,
  output logic [XLEN-1:0]   rd_data,
  output logic              csr_write,
  output logic [11:0]       csr_address,
  output logic [XLEN-1:0]   csr_data,
  output logic              traped,
  output logic              mret,
  output logic              interupt,
  output logic [4:0]        ecause,
  output logic [XLEN-1:0]   ecp,
  output logic              retired,
  output logic              sleeping,
  output logic [CNT_W-1:0]  instret_count,
  output logic [CNT_W-1:0]  trap_count
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SLEEP = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [4:0] CAUSE_EIP = 5'd11;
  localparam logic [4:0] CAUSE_SIP = 5'd3;
  localparam logic [4:0] CAUSE_TIP = 5'd7;

  logic [1:0]      state_q,       state_d;
  logic [XLEN-1:0] wfi_pc_q,      wfi_pc_d;
  logic            rd_we_q,       rd_we_d;
  logic [4:0]      rd_address_q,  rd_address_d;
  logic [XLEN-1:0] rd_data_q,     rd_data_d;
  logic            csr_write_q,   csr_write_d;
  logic [11:0]     csr_address_q, csr_address_d;
  logic [XLEN-1:0] csr_data_q,    csr_data_d;
  logic            traped_q,      traped_d;
  logic            mret_q,        mret_d;
  logic            interupt_q,    interupt_d;
  logic [4:0]      ecause_q,      ecause_d;
  logic [XLEN-1:0] ecp_q,         ecp_d;
  logic            retired_q,     retired_d;

  logic              transfer;
  logic [2:0]        core_en;
  logic [LIRQ_W-1:0] local_en;
  logic              take_irq;
  logic [4:0]        irq_cause;
  logic [XLEN-1:0]   wb_data;

  // Only SLEEP refuses work. FLUSH accepts an instruction so it can drop it.
  assign ready_out = (state_q != ST_SLEEP);
  assign sleeping  = (state_q == ST_SLEEP);
  assign transfer  = valid_in && ready_out;

  // Mask layout matches the pending vector: bit 0 tip, 1 sip, 2 eip,
  // bits 3.. local lines.
  assign core_en = {eip, sip, tip} & irq_mask[2:0];

  generate
    if (NUM_LOCAL_IRQ > 0) begin : g_local
      assign local_en = local_ip & irq_mask[LIRQ_W+2:3];
    end else begin : g_no_local
      assign local_en = '0;
    end
  endgenerate

  assign take_irq = global_ie && ((|core_en) || (|local_en));

  // Later assignments win. The loop runs upward so the highest local line
  // wins among the local lines. tip, sip and eip are applied last, so they
  // override all local lines in that order.
  always_comb begin
    irq_cause = 5'd0;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
      if (local_en[i]) begin
        irq_cause = 5'(16 + i);
      end
    end
    if (core_en[0]) irq_cause = CAUSE_TIP;
    if (core_en[1]) irq_cause = CAUSE_SIP;
    if (core_en[2]) irq_cause = CAUSE_EIP;
  end

  always_comb begin
    case (write_select_in)
      2'b00:   wb_data = alu_data_in;
      2'b01:   wb_data = csr_data_in;
      2'b10:   wb_data = load_data_in;
      default: wb_data = next_pc_in;
    endcase
  end

  // Next-state and output logic. Pulse outputs default low. Data, address,
  // cause and trap pc default to their held values.
  always_comb begin
    state_d       = state_q;
    wfi_pc_d      = wfi_pc_q;
    rd_we_d       = 1'b0;
    rd_address_d  = rd_address_q;
    rd_data_d     = rd_data_q;
    csr_write_d   = 1'b0;
    csr_address_d = csr_address_q;
    csr_data_d    = csr_data_q;
    traped_d      = 1'b0;
    mret_d        = 1'b0;
    interupt_d    = 1'b0;
    ecause_d      = ecause_q;
    ecp_d         = ecp_q;
    retired_d     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (transfer) begin
          if (take_irq) begin
            // An interrupt preempts everything else the instruction asked
            // for, including exception, mret and wfi.
            traped_d   = 1'b1;
            interupt_d = 1'b1;
            ecause_d   = irq_cause;
            ecp_d      = pc_in;
            state_d    = ST_FLUSH;
          end else if (exception_in) begin
            traped_d = 1'b1;
            ecause_d = {1'b0, ecause_in};
            ecp_d    = pc_in;
            state_d  = ST_FLUSH;
          end else begin
            retired_d     = 1'b1;
            rd_we_d       = (rd_address_in != 5'd0);
            rd_address_d  = rd_address_in;
            rd_data_d     = wb_data;
            csr_write_d   = csr_write_in;
            csr_address_d = csr_address_in;
            csr_data_d    = alu_data_in;
            mret_d        = mret_in;
            if (wfi_in) begin
              // Wake-up traps report the instruction after the WFI.
              wfi_pc_d = next_pc_in;
              state_d  = ST_SLEEP;
            end
          end
        end
      end

      ST_SLEEP: begin
        if (take_irq) begin
          traped_d   = 1'b1;
          interupt_d = 1'b1;
          ecause_d   = irq_cause;
          ecp_d      = wfi_pc_q;
          state_d    = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        // Anything transferred this cycle was fetched down the old path.
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wfi_pc_q      <= '0;
      rd_we_q       <= 1'b0;
      rd_address_q  <= '0;
      rd_data_q     <= '0;
      csr_write_q   <= 1'b0;
      csr_address_q <= '0;
      csr_data_q    <= '0;
      traped_q      <= 1'b0;
      mret_q        <= 1'b0;
      interupt_q    <= 1'b0;
      ecause_q      <= '0;
      ecp_q         <= '0;
      retired_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wfi_pc_q      <= wfi_pc_d;
      rd_we_q       <= rd_we_d;
      rd_address_q  <= rd_address_d;
      rd_data_q     <= rd_data_d;
      csr_write_q   <= csr_write_d;
      csr_address_q <= csr_address_d;
      csr_data_q    <= csr_data_d;
      traped_q      <= traped_d;
      mret_q        <= mret_d;
      interupt_q    <= interupt_d;
      ecause_q      <= ecause_d;
      ecp_q         <= ecp_d;
      retired_q     <= retired_d;
    end
  end

  assign rd_we       = rd_we_q;
  assign rd_address  = rd_address_q;
  assign rd_data     = rd_data_q;
  assign csr_write   = csr_write_q;
  assign csr_address = csr_address_q;
  assign csr_data    = csr_data_q;
  assign traped      = traped_q;
  assign mret        = mret_q;
  assign interupt    = interupt_q;
  assign ecause      = ecause_q;
  assign ecp         = ecp_q;
  assign retired     = retired_q;

`ifdef WB_PERF_COUNTERS_EN
  logic [CNT_W-1:0] instret_count_q, instret_count_d;
  logic [CNT_W-1:0] trap_count_q,    trap_count_d;

  // Counters advance in the same cycle that the matching pulse is
  // registered, so the count and the pulse become visible together.
  always_comb begin
    instret_count_d = instret_count_q + {{(CNT_W-1){1'b0}}, retired_d};
    trap_count_d    = trap_count_q    + {{(CNT_W-1){1'b0}}, traped_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_count_q <= '0;
      trap_count_q    <= '0;
    end else begin
      instret_count_q <= instret_count_d;
      trap_count_q    <= trap_count_d;
    end
  end

  assign instret_count = instret_count_q;
  assign trap_count    = trap_count_q;
`else
  assign instret_count = '0;
  assign trap_count    = '0;
`endif

endmodule

// File: tb/tb_writeback_commit.sv
module tb_writeback_commit;

   localparam int XLEN  = 32;
   localparam int NL    = 4;
   localparam int CNT_W = 4;

   logic            clk;
   logic            rst_n;
   logic            valid_in;
   logic            ready_out;
   logic [XLEN-1:0] pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in;
   logic [1:0]      write_select_in;
   logic [4:0]      rd_address_in;
   logic [11:0]     csr_address_in;
   logic            csr_write_in, mret_in, wfi_in, exception_in;
   logic [3:0]      ecause_in;
   logic            eip, sip, tip;
   logic [NL-1:0]   local_ip;
   logic [NL+2:0]   irq_mask;
   logic            global_ie;
   logic            rd_we;
   logic [4:0]      rd_address;
   logic [XLEN-1:0] rd_data;
   logic            csr_write;
   logic [11:0]     csr_address;
   logic [XLEN-1:0] csr_data;
   logic            traped, mret, interupt, retired, sleeping;
   logic [4:0]      ecause;
   logic [XLEN-1:0] ecp;
   logic [CNT_W-1:0] instret_count, trap_count;

   writeback_commit #(.XLEN(XLEN), .NUM_LOCAL_IRQ(NL), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
      .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
      .csr_data_in(csr_data_in), .load_data_in(load_data_in),
      .write_select_in(write_select_in), .rd_address_in(rd_address_in),
      .csr_address_in(csr_address_in), .csr_write_in(csr_write_in),
      .mret_in(mret_in), .wfi_in(wfi_in), .exception_in(exception_in),
      .ecause_in(ecause_in), .eip(eip), .sip(sip), .tip(tip),
      .local_ip(local_ip), .irq_mask(irq_mask), .global_ie(global_ie),
      .rd_we(rd_we), .rd_address(rd_address), .rd_data(rd_data),
      .csr_write(csr_write), .csr_address(csr_address), .csr_data(csr_data),
      .traped(traped), .mret(mret), .interupt(interupt), .ecause(ecause),
      .ecp(ecp), .retired(retired), .sleeping(sleeping),
      .instret_count(instret_count), .trap_count(trap_count)
   );

   typedef struct {
      logic [31:0] pc, nextPc, alu, csr, load;
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic [11:0] csrAddr;
      logic        csrWe, mretI, wfi, exc;
      logic [3:0]  cause;
   } instr_t;

   typedef struct {
      logic        isTrap;
      logic        rdWe;
      logic [4:0]  rdAddr;
      logic [31:0] rdData;
      logic        csrWe;
      logic [11:0] csrAddr;
      logic [31:0] csrData;
      logic        mretO;
      logic        intr;
      logic [4:0]  cause;
      logic [31:0] pcOut;
   } exp_t;

   exp_t   expQ[$];
   exp_t   monE;
   instr_t ins;
   int     compared   = 0;
   int     mismatched = 0;
   int     expRetires = 0;
   int     expTraps   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison funnels through here so the counts stay consistent.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic instr_t mkInstr(input logic [31:0] pc, input logic [31:0] alu,
                                      input logic [1:0] sel, input logic [4:0] rd);
      instr_t i;
      i.pc = pc; i.nextPc = pc + 32'd4; i.alu = alu; i.csr = 32'h0; i.load = 32'h0;
      i.sel = sel; i.rd = rd; i.csrAddr = 12'h0; i.csrWe = 1'b0; i.mretI = 1'b0;
      i.wfi = 1'b0; i.exc = 1'b0; i.cause = 4'h0;
      return i;
   endfunction

   function automatic exp_t mkRetire(input logic rdWe, input logic [4:0] rd, input logic [31:0] data,
                                     input logic csrWe, input logic [11:0] ca, input logic [31:0] cd,
                                     input logic m);
      exp_t e;
      e.isTrap = 1'b0; e.rdWe = rdWe; e.rdAddr = rd; e.rdData = data; e.csrWe = csrWe;
      e.csrAddr = ca; e.csrData = cd; e.mretO = m; e.intr = 1'b0; e.cause = 5'd0; e.pcOut = 32'h0;
      return e;
   endfunction

   function automatic exp_t mkTrap(input logic intr, input logic [4:0] cause, input logic [31:0] pc);
      exp_t e;
      e = mkRetire(1'b0, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0);
      e.isTrap = 1'b1; e.intr = intr; e.cause = cause; e.pcOut = pc;
      return e;
   endfunction

   task automatic pushExpect(input exp_t e);
      expQ.push_back(e);
      if (e.isTrap) expTraps++;
      else          expRetires++;
   endtask

   // kind: 0 = transfer expected to be discarded, 1 = expect the given event
   task automatic applyStimulus(input instr_t i, input int kind, input exp_t e);
      @(negedge clk);
      valid_in        = 1'b1;
      pc_in           = i.pc;
      next_pc_in      = i.nextPc;
      alu_data_in     = i.alu;
      csr_data_in     = i.csr;
      load_data_in    = i.load;
      write_select_in = i.sel;
      rd_address_in   = i.rd;
      csr_address_in  = i.csrAddr;
      csr_write_in    = i.csrWe;
      mret_in         = i.mretI;
      wfi_in          = i.wfi;
      exception_in    = i.exc;
      ecause_in       = i.cause;
      if (kind == 1) pushExpect(e);
   endtask

   task automatic idleCycles(input int n);
      @(negedge clk);
      valid_in = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   // Monitor: pops one expectation for every pulse event the DUT shows.
   always @(negedge clk) begin
      if (rst_n) begin
         if (retired || traped) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_event", {62'd0, retired, traped}, 64'd0);
            end else begin
               monE = expQ.pop_front();
               checkOutput("traped",    traped,    monE.isTrap);
               checkOutput("retired",   retired,   !monE.isTrap);
               checkOutput("interupt",  interupt,  monE.intr);
               checkOutput("rd_we",     rd_we,     monE.rdWe);
               checkOutput("csr_write", csr_write, monE.csrWe);
               checkOutput("mret",      mret,      monE.mretO);
               if (monE.isTrap) begin
                  checkOutput("ecause", ecause, monE.cause);
                  checkOutput("ecp",    ecp,    monE.pcOut);
               end
               if (!monE.isTrap && monE.rdWe) begin
                  checkOutput("rd_address", rd_address, monE.rdAddr);
                  checkOutput("rd_data",    rd_data,    monE.rdData);
               end
               if (monE.csrWe) begin
                  checkOutput("csr_address", csr_address, monE.csrAddr);
                  checkOutput("csr_data",    csr_data,    monE.csrData);
               end
            end
         end else begin
            checkOutput("idle_pulses", {60'd0, rd_we, csr_write, mret, interupt}, 64'd0);
         end
      end
   end

   initial begin : mainSeq
      logic [CNT_W-1:0] expInstret, expTrapCnt;
      exp_t none;
      none = mkRetire(1'b0, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0);

      // Reset held with a valid instruction on the inputs.
      rst_n = 1'b0; eip = 1'b0; sip = 1'b0; tip = 1'b0; local_ip = '0;
      irq_mask = '1; global_ie = 1'b1;
      ins = mkInstr(32'h40, 32'h11, 2'b00, 5'd2);
      valid_in = 1'b1; pc_in = ins.pc; next_pc_in = ins.nextPc; alu_data_in = ins.alu;
      csr_data_in = 32'h0; load_data_in = 32'h0; write_select_in = 2'b00; rd_address_in = 5'd2;
      csr_address_in = 12'h0; csr_write_in = 1'b0; mret_in = 1'b0; wfi_in = 1'b0;
      exception_in = 1'b0; ecause_in = 4'h0;
      repeat (3) @(negedge clk);
      checkOutput("reset_rd_we",    rd_we,    0);
      checkOutput("reset_retired",  retired,  0);
      checkOutput("reset_traped",   traped,   0);
      checkOutput("reset_rd_data",  rd_data,  0);
      checkOutput("reset_ecp",      ecp,      0);
      checkOutput("reset_sleeping", sleeping, 0);
      checkOutput("reset_instret",  instret_count, 0);
      valid_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idleCycles(1);
      checkOutput("ready_after_reset", ready_out, 1);

      // ALU retire.
      ins = mkInstr(32'h100, 32'hDEADBEEF, 2'b00, 5'd5);
      applyStimulus(ins, 1, mkRetire(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 12'h0, 32'h0, 1'b0));
      // Load into x0: retires without a register write.
      ins = mkInstr(32'h104, 32'h0, 2'b10, 5'd0); ins.load = 32'h1234;
      applyStimulus(ins, 1, mkRetire(1'b0, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0));
      // CSR read into rd with a CSR write of the ALU value.
      ins = mkInstr(32'h108, 32'h55, 2'b01, 5'd7); ins.csr = 32'hCAFE;
      ins.csrWe = 1'b1; ins.csrAddr = 12'h300;
      applyStimulus(ins, 1, mkRetire(1'b1, 5'd7, 32'hCAFE, 1'b1, 12'h300, 32'h55, 1'b0));
      // next_pc writeback plus mret.
      ins = mkInstr(32'h10C, 32'h0, 2'b11, 5'd1); ins.mretI = 1'b1;
      applyStimulus(ins, 1, mkRetire(1'b1, 5'd1, 32'h110, 1'b0, 12'h0, 32'h0, 1'b1));

      // Exception, then a back-to-back transfer that must be discarded.
      ins = mkInstr(32'h200, 32'h0, 2'b00, 5'd8); ins.exc = 1'b1; ins.cause = 4'd2;
      applyStimulus(ins, 1, mkTrap(1'b0, 5'd2, 32'h200));
      ins = mkInstr(32'h204, 32'h99, 2'b00, 5'd9);
      applyStimulus(ins, 0, none);
      ins = mkInstr(32'h300, 32'h77, 2'b00, 5'd3);
      applyStimulus(ins, 1, mkRetire(1'b1, 5'd3, 32'h77, 1'b0, 12'h0, 32'h0, 1'b0));
      idleCycles(2);

      // Interrupt priority: eip over tip over local[0].
      eip = 1'b1; tip = 1'b1; local_ip = 4'b0001; irq_mask = '1;
      idleCycles(3);
      ins = mkInstr(32'h400, 32'h1, 2'b00, 5'd4);
      applyStimulus(ins, 1, mkTrap(1'b1, 5'd11, 32'h400));
      idleCycles(1);
      irq_mask = 7'b1111_011;
      ins = mkInstr(32'h404, 32'h1, 2'b00, 5'd4);
      applyStimulus(ins, 1, mkTrap(1'b1, 5'd7, 32'h404));
      idleCycles(1);
      irq_mask = 7'b1111_000;
      ins = mkInstr(32'h408, 32'h1, 2'b00, 5'd4);
      applyStimulus(ins, 1, mkTrap(1'b1, 5'd16, 32'h408));
      idleCycles(1);
      local_ip = 4'b1001;
      ins = mkInstr(32'h40C, 32'h1, 2'b00, 5'd4);
      applyStimulus(ins, 1, mkTrap(1'b1, 5'd19, 32'h40C));
      idleCycles(1);
      // Global disable: the instruction retires normally.
      global_ie = 1'b0; irq_mask = '1;
      ins = mkInstr(32'h410, 32'hABCD, 2'b00, 5'd6);
      applyStimulus(ins, 1, mkRetire(1'b1, 5'd6, 32'hABCD, 1'b0, 12'h0, 32'h0, 1'b0));
      idleCycles(1);
      global_ie = 1'b1; eip = 1'b0; local_ip = '0;

      // Interrupt beats exception, mret and wfi on the same instruction.
      ins = mkInstr(32'h500, 32'h1, 2'b00, 5'd4);
      ins.exc = 1'b1; ins.cause = 4'd5; ins.mretI = 1'b1; ins.wfi = 1'b1;
      applyStimulus(ins, 1, mkTrap(1'b1, 5'd7, 32'h500));
      idleCycles(1);
      checkOutput("combo_not_sleeping", sleeping, 0);
      tip = 1'b0;
      idleCycles(1);

      // WFI: sleep, ignore a masked line, wake on tip.
      ins = mkInstr(32'h300, 32'h0, 2'b00, 5'd0); ins.nextPc = 32'h304; ins.wfi = 1'b1;
      applyStimulus(ins, 1, mkRetire(1'b0, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0));
      idleCycles(1);
      checkOutput("wfi_sleeping", sleeping,  1);
      checkOutput("wfi_ready",    ready_out, 0);
      irq_mask = 7'b1111_101; sip = 1'b1;
      idleCycles(3);
      checkOutput("masked_sip_no_wake", sleeping, 1);
      irq_mask = 7'b1111_001;
      idleCycles(1);
      tip = 1'b1;
      pushExpect(mkTrap(1'b1, 5'd7, 32'h304));
      idleCycles(1);
      checkOutput("wake_not_sleeping", sleeping,  0);
      checkOutput("wake_ready",        ready_out, 1);
      tip = 1'b0; sip = 1'b0; irq_mask = '1;
      idleCycles(2);

      // Seventeen retires to exercise counter wrap.
      for (int k = 0; k < 17; k++) begin
         ins = mkInstr(32'h600 + 32'(4 * k), 32'(k * 3 + 1), 2'b00, 5'(k + 10));
         applyStimulus(ins, 1, mkRetire(1'b1, 5'(k + 10), 32'(k * 3 + 1), 1'b0, 12'h0, 32'h0, 1'b0));
      end
      idleCycles(3);

      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
`ifdef WB_PERF_COUNTERS_EN
      expInstret = CNT_W'(expRetires);
      expTrapCnt = CNT_W'(expTraps);
`else
      expInstret = '0;
      expTrapCnt = '0;
`endif
      checkOutput("instret_count", instret_count, expInstret);
      checkOutput("trap_count",    trap_count,    expTrapCnt);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
